// File: rtl/instruction_issuer_pkg.sv
// rtl/instruction_issuer_pkg.sv - shared widths, opcodes and FSM encoding for the instruction issuer
package instruction_issuer_pkg;

    localparam int INSTRUCTION_WIDTH = 32;
    localparam int OPCODE_WIDTH      = 4;
    localparam int RESULT_WIDTH      = 12;

    localparam logic [OPCODE_WIDTH-1:0] OP_NOP   = 4'd0;
    localparam logic [OPCODE_WIDTH-1:0] OP_PLOT  = 4'd1;
    localparam logic [OPCODE_WIDTH-1:0] OP_READ  = 4'd2;
    localparam logic [OPCODE_WIDTH-1:0] OP_WRITE = 4'd3;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_BUSY = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_RESULT    = 2'd3
    } state_t;

    // Opcode lives in the top bits of every instruction word
    function automatic logic [OPCODE_WIDTH-1:0] get_opcode(input logic [INSTRUCTION_WIDTH-1:0] ins);
        return ins[INSTRUCTION_WIDTH-1 -: OPCODE_WIDTH];
    endfunction

endpackage

// File: rtl/instruction_issuer_fifo.sv
// rtl/instruction_issuer_fifo.sv - synchronous show-ahead FIFO holding queued instructions
module issuer_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: an empty FIFO never exposes its contents
    always_ff @(posedge clock) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/instruction_issuer.sv
// rtl/instruction_issuer.sv - issues queued instructions over the datapath start/finished handshake
module instruction_issuer
    import instruction_issuer_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                         clock,
    input  logic                         resetn,
    input  logic [INSTRUCTION_WIDTH-1:0] in_instruction,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [INSTRUCTION_WIDTH-1:0] dp_instruction,
    output logic                         dp_start,
    input  logic                         dp_finished,
    input  logic [RESULT_WIDTH-1:0]      dp_result,
    output logic [RESULT_WIDTH-1:0]      rd_data,
    output logic                         rd_valid,
    input  logic                         rd_ready,
    output logic                         busy,
    output logic                         error,
    input  logic                         err_clear
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t                        r_state;
    state_t                        w_state_next;
    logic [INSTRUCTION_WIDTH-1:0]  r_dp_instruction;
    logic                          r_dp_start;
    logic [RESULT_WIDTH-1:0]       r_rd_data;
    logic                          r_rd_valid;
    logic                          r_error;
    logic [WD_W-1:0]               r_wdog;

    logic [INSTRUCTION_WIDTH-1:0]  w_head;
    logic [$clog2(FIFO_DEPTH):0]   w_count;
    logic                          w_full;
    logic                          w_empty;
    logic [OPCODE_WIDTH-1:0]       w_head_op;
    logic [OPCODE_WIDTH-1:0]       w_cur_op;
    logic                          w_pop;
    logic                          w_issue;
    logic                          w_err_set;
    logic                          w_capture;
    logic                          w_rd_clear;
    logic                          w_wdog_clr;
    logic                          w_wdog_inc;
    logic                          w_timeout;

    issuer_fifo #(
        .WIDTH (INSTRUCTION_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .resetn  (resetn),
        .i_push  (in_valid && in_ready),
        .i_data  (in_instruction),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_head_op      = get_opcode(w_head);
    assign w_cur_op       = get_opcode(r_dp_instruction);
    assign w_timeout      = (r_wdog == WD_W'(TIMEOUT_CYCLES - 1));
    assign in_ready       = !w_full;
    assign busy           = (r_state != ST_IDLE) || (w_count != '0);
    assign dp_instruction = r_dp_instruction;
    assign dp_start       = r_dp_start;
    assign rd_data        = r_rd_data;
    assign rd_valid       = r_rd_valid;
    assign error          = r_error;

    // State register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) r_state <= ST_IDLE;
        else         r_state <= w_state_next;
    end

    // Next-state and control strobes; completion beats the watchdog in WAIT_DONE
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_issue      = 1'b0;
        w_err_set    = 1'b0;
        w_capture    = 1'b0;
        w_rd_clear   = 1'b0;
        w_wdog_clr   = 1'b0;
        w_wdog_inc   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty && dp_finished) begin
                    w_pop = 1'b1;
                    case (w_head_op)
                        OP_NOP: ;
                        OP_PLOT, OP_READ, OP_WRITE: begin
                            w_issue      = 1'b1;
                            w_wdog_clr   = 1'b1;
                            w_state_next = ST_WAIT_BUSY;
                        end
                        default: w_err_set = 1'b1;
                    endcase
                end
            end
            ST_WAIT_BUSY: begin
                if (w_timeout) begin
                    w_err_set    = 1'b1;
                    w_state_next = ST_IDLE;
                end else begin
                    w_wdog_inc = 1'b1;
                    if (!dp_finished) w_state_next = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (dp_finished) begin
                    if (w_cur_op == OP_READ) begin
                        w_capture    = 1'b1;
                        w_state_next = ST_RESULT;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end else if (w_timeout) begin
                    w_err_set    = 1'b1;
                    w_state_next = ST_IDLE;
                end else begin
                    w_wdog_inc = 1'b1;
                end
            end
            ST_RESULT: begin
                if (rd_ready) begin
                    w_rd_clear   = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Datapath-facing registers, read result, sticky error and watchdog
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_dp_instruction <= '0;
            r_dp_start       <= 1'b0;
            r_rd_data        <= '0;
            r_rd_valid       <= 1'b0;
            r_error          <= 1'b0;
            r_wdog           <= '0;
        end else begin
            r_dp_start <= w_issue;
            if (w_issue) r_dp_instruction <= w_head;
            if (w_capture) begin
                r_rd_data  <= dp_result;
                r_rd_valid <= 1'b1;
            end else if (w_rd_clear) begin
                r_rd_valid <= 1'b0;
            end
            if (w_err_set)      r_error <= 1'b1;
            else if (err_clear) r_error <= 1'b0;
            if (w_wdog_clr)      r_wdog <= '0;
            else if (w_wdog_inc) r_wdog <= r_wdog + 1'b1;
        end
    end

endmodule

// File: doc/instruction_issuer.md
Name: instruction_issuer

Overview:
Upstream feeder for the instruction datapath. Buffers instructions from the host/neuroevolution controller in a small FIFO and issues them one at a time over the datapath's start/finished handshake. Holds each instruction stable for its whole execution, returns memory-read results through a valid/ready port, and watches for a hung datapath.

Parameters:
FIFO_DEPTH, 8, instruction FIFO entries (power of 2, >=2)
TIMEOUT_CYCLES, 1024, max cycles allowed in WAIT_BUSY+WAIT_DONE before abort

Ports:
clock  in  1  system clock
resetn  in  1  asynchronous active-low reset
in_instruction  in  INSTRUCTION_WIDTH  instruction from producer
in_valid  in  1  producer has an instruction
in_ready  out  1  FIFO can accept (count < FIFO_DEPTH)
dp_instruction  out  INSTRUCTION_WIDTH  held instruction to datapath
dp_start  out  1  one-cycle issue pulse
dp_finished  in  1  datapath idle/done flag
dp_result  in  RESULT_WIDTH  datapath result register
rd_data  out  RESULT_WIDTH  captured read result
rd_valid  out  1  rd_data valid
rd_ready  in  1  consumer accepts rd_data
busy  out  1  state != IDLE or FIFO non-empty
error  out  1  sticky: timeout or illegal opcode
err_clear  in  1  clears error

Behaviour:
- Clock and reset: single clock `clock`; reset `resetn` is asynchronous, active-low.
- Reset values: in_ready=1, dp_instruction=0, dp_start=0, rd_data=0, rd_valid=0, busy=0, error=0, FIFO empty, state=IDLE, watchdog=0. Reset mid-operation aborts everything and discards FIFO contents.
- Opcode field: dp_instruction[INSTRUCTION_WIDTH-1 -: OPCODE_WIDTH]. 0=NOP, 1=plot, 2=mem read, 3=mem write, other=illegal.
- FIFO push: in_valid && in_ready. in_ready depends only on count, not on a same-cycle pop; no push when full. Push and pop in the same cycle leave count unchanged.
- IDLE: if FIFO non-empty and dp_finished=1, pop head.
  - NOP: retired in this cycle, no datapath activity; stay IDLE.
  - Illegal opcode: set error, drop the instruction; stay IDLE.
  - Otherwise: at the same edge, load dp_instruction and set dp_start=1; go to WAIT_BUSY.
- WAIT_BUSY: dp_start=0 (pulse is exactly one cycle). Wait for dp_finished=0, then go to WAIT_DONE.
- WAIT_DONE: wait for dp_finished=1.
  - Opcode 2: capture rd_data=dp_result, set rd_valid=1, go to RESULT.
  - Opcodes 1 and 3: go to IDLE.
- RESULT: hold rd_data and rd_valid until rd_ready=1, then clear rd_valid and go to IDLE. No further issue while a result is pending.
- dp_instruction stays unchanged from the issue edge until the next issue, including while in IDLE.
- Watchdog: counts cycles in WAIT_BUSY and WAIT_DONE, and resets on entering WAIT_BUSY. At TIMEOUT_CYCLES: set error, go to IDLE, no result produced. Whether the datapath later raises finished is immaterial.
- err_clear clears error. If err_clear and a new error event occur in the same cycle, the error wins.
- Minimum issue-to-issue spacing is 4 cycles (IDLE, WAIT_BUSY, WAIT_DONE, IDLE); a read adds at least 1 cycle in RESULT.
- Back-to-back issue: next pop may occur the cycle after returning to IDLE.

Decomposition:
- Shared package/header: INSTRUCTION_WIDTH=32, OPCODE_WIDTH=4, RESULT_WIDTH=12, opcode constants OP_NOP/OP_PLOT/OP_READ/OP_WRITE, state encoding.
- Sub-module: issuer_fifo (synchronous FIFO, parameterised width/depth, push/pop/count/full/empty).
- FSM and watchdog live in instruction_issuer.

Test Plan:
- Push 0x2000_0123 with dp model returning 0x5A5 after 2 cycles -> exactly one dp_start pulse; dp_instruction=0x2000_0123 through done; rd_valid=1 with rd_data=0x5A5; held 3 cycles with rd_ready=0, cleared the cycle after rd_ready=1.
- Push 8 plot instructions while dp stalled at finished=1 → 0 for 50 cycles -> in_ready=0 after the 8th push; a 9th in_valid is not accepted; all 8 later issued in order.
- Push 0x0000_0000 (NOP) then 0x1000_8405 -> no dp_start for the NOP; one dp_start with dp_instruction=0x1000_8405.
- Push 0x7000_0000 -> error=1, no dp_start; err_clear pulse -> error=0.
- dp model never deasserts finished after start, with TIMEOUT_CYCLES=16 -> error=1 16 cycles after issue; FIFO next entry then issues.
- Assert resetn=0 mid-WAIT_DONE with 3 entries queued -> all outputs at reset values immediately (asynchronously); FIFO empty after release.
